and_or_accum: RTL and testbench

Parametrised, pipelined successor to the processor's 2-bit AND-OR gating block. It computes `base | OR_k(data_k & en_k)` over NCH channels of WIDTH bits, and ORs the results of successive beats into one frame result. The frame result and a saturating beat count are held in an output register behind valid/ready handshakes. It sits between the decode/branch-condition logic and any consumer that needs a merged, back-pressurable flag vector.

---
 rtl/and_or_accum_if.sv | 28 ++
 rtl/and_or_accum.sv | 127 ++++++++++++
 tb/tb_and_or_accum.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/and_or_accum_if.sv
// Beat/result handshake bundle for and_or_accum.
// master drives beats and takes results; slave is the accumulator.
interface and_or_accum_if #(
  parameter int WIDTH = 2,
  parameter int NCH   = 3,
  parameter int CW    = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [WIDTH-1:0]     base;
  logic [NCH*WIDTH-1:0] data;
  logic [NCH-1:0]       en;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [CW-1:0]        out_beats;

  modport master (
    output in_valid, in_last, base, data, en, out_ready,
    input  in_ready, out_valid, out_data, out_beats
  );

  modport slave (
    input  in_valid, in_last, base, data, en, out_ready,
    output in_ready, out_valid, out_data, out_beats
  );
endinterface

// File: rtl/and_or_accum.sv
// Gated AND-OR flag merge with per-frame OR accumulation, a saturating
// beat counter and a single-entry valid/ready output register.

// One gated channel: passes its data only when enabled.
module and_or_lane #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  output logic [WIDTH-1:0] gated
);
  assign gated = data & {WIDTH{en}};
endmodule

module and_or_accum #(
  parameter int WIDTH = 2,
  parameter int NCH   = 3,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  and_or_accum_if.slave bus
);
  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_ACC   = 1'b1;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [NCH-1:0][WIDTH-1:0] gated;
  logic [WIDTH-1:0]          gated_or;
  logic [WIDTH-1:0]          term;
  logic [0:0]                state;
  logic [WIDTH-1:0]          acc;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_inc;
  logic                      accept;
  logic                      load;
  logic [WIDTH-1:0]          load_data;
  logic [CW-1:0]             load_beats;
  logic                      out_valid_q;
  logic [WIDTH-1:0]          out_data_q;
  logic [CW-1:0]             out_beats_q;

  // Per-channel gating, one lane instance per channel.
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    and_or_lane #(.WIDTH(WIDTH)) u_lane (
      .data  (bus.data[k*WIDTH +: WIDTH]),
      .en    (bus.en[k]),
      .gated (gated[k])
    );
  end

  // OR-reduce the gated channels; purely bitwise, no carries.
  always_comb begin
    gated_or = '0;
    for (int k = 0; k < NCH; k++) gated_or = gated_or | gated[k];
  end

  assign term = bus.base | gated_or;

  // Ready only depends on the output slot: free now or freed this cycle.
  // Non-last beats are also held off while blocked so ordering stays trivial.
  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = accept & bus.in_last;

  // Counter clamps at all-ones instead of wrapping.
  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);

  // Result presented to the output register when a frame closes.
  always_comb begin
    load_data  = term;
    load_beats = CW'(1);
    if (state == S_ACC) begin
      load_data  = acc | term;
      load_beats = cnt_inc;
    end
  end

  // Frame FSM: collects non-last beats into acc/cnt, clears on close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      case (state)
        S_IDLE: begin
          if (!bus.in_last) begin
            acc   <= term;
            cnt   <= CW'(1);
            state <= S_ACC;
          end
        end
        default: begin
          if (bus.in_last) begin
            acc   <= '0;
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            acc <= acc | term;
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

  // Output slot: load wins over consume, giving bubble-free hand-over;
  // data/beats only change on a load so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= load_data;
      out_beats_q <= load_beats;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;
endmodule

// File: tb/tb_and_or_accum.sv
// Directed bench for and_or_accum (WIDTH=2, NCH=3, CW=8).
// Channels fixed at ch0=01, ch1=10, ch2=11.
module tb_and_or_accum;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  and_or_accum_if #(.WIDTH(2), .NCH(3), .CW(8)) bus ();

  and_or_accum #(.WIDTH(2), .NCH(3), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] b, input logic [2:0] e, input logic l, input logic v);
    bus.base     = b;
    bus.en       = e;
    bus.in_last  = l;
    bus.in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.data      = 6'b11_10_01;
    bus.out_ready = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_beats", 32'(bus.out_beats), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // single-beat frame: 01|10 = 11
    drive(2'b00, 3'b011, 1'b1, 1'b1);
    step();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data",  32'(bus.out_data),  32'd3);
    check("single_beats", 32'(bus.out_beats), 32'd1);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();
    check("single_drop", 32'(bus.out_valid), 32'd0);

    // two-beat frame: 01 then 10
    drive(2'b01, 3'b000, 1'b0, 1'b1);
    step();
    check("two_mid_valid", 32'(bus.out_valid), 32'd0);
    drive(2'b00, 3'b010, 1'b1, 1'b1);
    step();
    check("two_valid", 32'(bus.out_valid), 32'd1);
    check("two_data",  32'(bus.out_data),  32'd3);
    check("two_beats", 32'(bus.out_beats), 32'd2);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();

    // back-to-back one-beat frames
    drive(2'b01, 3'b000, 1'b1, 1'b1);
    step();
    check("tput0_data", 32'(bus.out_data), 32'd1);
    drive(2'b10, 3'b000, 1'b1, 1'b1);
    step();
    check("tput1_valid", 32'(bus.out_valid), 32'd1);
    check("tput1_data",  32'(bus.out_data),  32'd2);
    drive(2'b00, 3'b000, 1'b1, 1'b1);
    step();
    check("tput2_valid", 32'(bus.out_valid), 32'd1);
    check("tput2_data",  32'(bus.out_data),  32'd0);
    check("tput2_beats", 32'(bus.out_beats), 32'd1);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();
    check("tput_drain", 32'(bus.out_valid), 32'd0);

    // back-pressure: hold 10, offer a blocked beat for 5 cycles
    bus.out_ready = 1'b0;
    drive(2'b10, 3'b000, 1'b1, 1'b1);
    step();
    check("bp_load_valid", 32'(bus.out_valid), 32'd1);
    check("bp_load_data",  32'(bus.out_data),  32'd2);
    drive(2'b11, 3'b111, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
      check("bp_hold_data",  32'(bus.out_data),  32'd2);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    drive(2'b00, 3'b001, 1'b1, 1'b1);
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);
    check("bp_next_data",  32'(bus.out_data),  32'd1);
    check("bp_next_beats", 32'(bus.out_beats), 32'd1);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();
    check("bp_drain", 32'(bus.out_valid), 32'd0);

    // reset mid-frame: out_data still holds 01 from above
    drive(2'b11, 3'b000, 1'b0, 1'b1);
    step();
    step();
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",  32'(bus.out_data),  32'd0);
    check("mid_rst_beats", 32'(bus.out_beats), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    drive(2'b00, 3'b000, 1'b1, 1'b1);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_data",  32'(bus.out_data),  32'd0);
    check("post_rst_beats", 32'(bus.out_beats), 32'd1);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();

    // saturation: 299 non-last beats then a last one
    drive(2'b00, 3'b000, 1'b0, 1'b1);
    repeat (299) step();
    check("sat_mid_valid", 32'(bus.out_valid), 32'd0);
    drive(2'b00, 3'b000, 1'b1, 1'b1);
    step();
    check("sat_valid", 32'(bus.out_valid), 32'd1);
    check("sat_beats", 32'(bus.out_beats), 32'd255);
    check("sat_data",  32'(bus.out_data),  32'd0);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();

    // idle input: 3 accepted non-last beats with gaps, junk while invalid
    drive(2'b00, 3'b001, 1'b0, 1'b1);
    step();
    drive(2'b10, 3'b111, 1'b1, 1'b0);
    step();
    drive(2'b00, 3'b000, 1'b0, 1'b1);
    step();
    drive(2'b10, 3'b111, 1'b1, 1'b0);
    step();
    drive(2'b00, 3'b000, 1'b0, 1'b1);
    step();
    drive(2'b10, 3'b110, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_valid", 32'(bus.out_valid), 32'd0);
    end
    drive(2'b00, 3'b000, 1'b1, 1'b1);
    step();
    check("idle_last_valid", 32'(bus.out_valid), 32'd1);
    check("idle_last_beats", 32'(bus.out_beats), 32'd4);
    check("idle_last_data",  32'(bus.out_data),  32'd1);
    drive(2'b00, 3'b000, 1'b0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
